uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8-bit receiver.
- Oversampled serial input with a runtime-programmable prescaler.
- Configurable data width; start-bit glitch rejection.
- Framing and overrun detection.
- Valid/ready output handshake so a downstream FIFO or controller can apply backpressure.
- Sits between the asynchronous rx pin and the byte-consumer logic.

---
 rtl/uart_rx_param.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with runtime prescaler, glitch rejection, framing/overrun flags and
// a valid/ready output. Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects sense).
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PRESC_W    = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PRESC_W-1:0]   sample_max_count,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] SAMPLE_PT = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic                 rx_meta, rx_s, rx_prev;
    logic [PRESC_W-1:0]   presc, presc_max;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick, sample, bit_end, fall, capture;

    assign tick    = (presc == presc_max);
    assign sample  = tick && (tick_cnt == SAMPLE_PT);
    assign bit_end = tick && (tick_cnt == BIT_END);
    assign fall    = rx_prev && !rx_s;
    assign capture = (state == ST_STOP) && sample;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0;
`endif

    // The prescaler terminal count is latched at each wrap so a change never shortens a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            presc     <= '0;
            presc_max <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= ST_IDLE;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            if ((state == ST_IDLE && fall) || tick) begin
                presc     <= '0;
                presc_max <= sample_max_count;
            end else begin
                presc <= presc + 1'b1;
            end

            if (state == ST_IDLE && fall)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (tick_cnt == BIT_END) ? '0 : tick_cnt + 1'b1;

            case (state)
                ST_IDLE: if (fall) state <= ST_START;
                ST_START: begin
                    if (sample && rx_s) begin
                        state <= ST_IDLE;
                    end else if (bit_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (sample)
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT)
                            state <= ST_AFTER_DATA;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample)
                        par_bad <= (^shift_reg) ^ rx_s ^ (PARITY_ODD != 0);
                    if (bit_end)
                        state <= ST_STOP;
                end
`endif
                // Leave at mid-stop so a start bit directly behind this frame is caught.
                ST_STOP: if (sample) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (capture) begin
                if (!rx_valid || rx_ready) begin
                    rx_data   <= shift_reg;
                    frame_err <= ~rx_s;
                    rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par_bad;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
